// File: rtl/nios_system_sysid_checker.sv
// Purpose: Avalon-MM master that reads sysid word 0 (ID) and word 1 (timestamp) and flags any mismatch or timeout.
// Latency: start -> done is 5 cycles with a zero-wait, zero-latency slave; each waitrequest/latency cycle adds one.
// Backpressure: read/address held stable while avm_waitrequest=1; start while busy is dropped, not queued.
// Build option: define SYSID_CHECK_PERIODIC_EN to re-run the check every PERIOD_CYCLES idle cycles.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1477941732,
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef SYSID_CHECK_PERIODIC_EN
  , parameter int unsigned PERIOD_CYCLES = 1000000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_ID  = 3'd1,
    S_WAIT_ID = 3'd2,
    S_REQ_TS  = 3'd3,
    S_WAIT_TS = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  // Last count value before the watchdog fires; the count starts at 0 on REQ entry.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic        start_q;
  logic        busy_q, done_q, pass_q, id_mm_q, ts_mm_q, tmo_q;
  logic        start_any, start_acc;
  logic        is_req, in_id, in_ts, rd_accept, data_ok, tmo_hit;

  assign is_req    = (state == S_REQ_ID) || (state == S_REQ_TS);
  assign in_id     = (state == S_REQ_ID) || (state == S_WAIT_ID);
  assign in_ts     = (state == S_REQ_TS) || (state == S_WAIT_TS);
  assign rd_accept = is_req && !avm_waitrequest;
  // Data counts in WAIT_x, or in REQ_x when the zero-latency slave returns it on the accept edge.
  assign data_ok   = avm_readdatavalid &&
                     (rd_accept || (state == S_WAIT_ID) || (state == S_WAIT_TS));
  assign tmo_hit   = (in_id || in_ts) && !data_ok && (tmo_cnt == TMO_LAST);
  // busy_q covers the start_q cycle too, so a second start cannot slip in before REQ_ID.
  assign start_acc = start_any && (state == S_IDLE) && !busy_q;

`ifdef SYSID_CHECK_PERIODIC_EN
  logic [31:0] period_cnt;
  logic        start_int;

  assign start_int = !busy_q && (period_cnt == 32'(PERIOD_CYCLES));
  assign start_any = start || start_int;

  // Period counter: frozen while busy, restarted by any accepted start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (start_acc) begin
      period_cnt <= '0;
    end else if (!busy_q) begin
      period_cnt <= period_cnt + 32'd1;
    end
  end
`else
  assign start_any = start;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: data wins over the watchdog when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_q) state_nxt = S_REQ_ID;
      end
      S_REQ_ID: begin
        if (data_ok)        state_nxt = S_REQ_TS;
        else if (tmo_hit)   state_nxt = S_FIN;
        else if (rd_accept) state_nxt = S_WAIT_ID;
      end
      S_WAIT_ID: begin
        if (data_ok)        state_nxt = S_REQ_TS;
        else if (tmo_hit)   state_nxt = S_FIN;
      end
      S_REQ_TS: begin
        if (data_ok || tmo_hit) state_nxt = S_FIN;
        else if (rd_accept)     state_nxt = S_WAIT_TS;
      end
      S_WAIT_TS: begin
        if (data_ok || tmo_hit) state_nxt = S_FIN;
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus outputs decode straight from state so reset removes the request immediately.
  always_comb begin
    avm_read    = is_req;
    avm_address = (state == S_REQ_TS);
  end

  // Watchdog: cleared on entry to a request, counts every cycle of request and wait.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if ((state_nxt != state) &&
                 ((state_nxt == S_REQ_ID) || (state_nxt == S_REQ_TS))) begin
      tmo_cnt <= '0;
    end else if (in_id || in_ts) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Status flags: cleared on accepted start, set by compares/watchdog, summarised in FIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      id_mm_q <= 1'b0;
      ts_mm_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (start_acc) begin
        start_q <= 1'b1;
        busy_q  <= 1'b1;
        pass_q  <= 1'b0;
        id_mm_q <= 1'b0;
        ts_mm_q <= 1'b0;
        tmo_q   <= 1'b0;
      end
      if (data_ok && in_id) id_mm_q <= (avm_readdata != EXPECTED_ID);
      if (data_ok && in_ts) ts_mm_q <= (avm_readdata != EXPECTED_TS);
      if (tmo_hit)          tmo_q   <= 1'b1;
      if (state == S_FIN) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
        pass_q <= !id_mm_q && !ts_mm_q && !tmo_q;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: vector table over slave wait/latency/data patterns,
// plus reset-mid-read, start-while-busy and periodic/no-activity sequences.
// Uses TIMEOUT_CYCLES=8 and (periodic build) PERIOD_CYCLES=20.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS = 32'd1477941732;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;

  nios_system_sysid_checker #(
    .EXPECTED_ID(32'h0000_0000),
    .EXPECTED_TS(TS),
    .TIMEOUT_CYCLES(8)
`ifdef SYSID_CHECK_PERIODIC_EN
    , .PERIOD_CYCLES(20)
`endif
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Slave model configuration and observation state.
  logic [31:0] cfg_id, cfg_ts;
  int          cfg_ws, cfg_lat;
  bit          cfg_resp;
  int          ws_cnt, pend, nreads, ndone, cyc;
  bit          pend_addr, prev_wait, prev_addr, unstable;
  int          acc_addr [2];
  int          done_at [3];

  task automatic reset_slave(input logic [31:0] id_v, input logic [31:0] ts_v,
                             input int ws, input int lat, input bit resp);
    cfg_id = id_v; cfg_ts = ts_v; cfg_ws = ws; cfg_lat = lat; cfg_resp = resp;
    ws_cnt = 0; pend = 0; nreads = 0; ndone = 0;
    prev_wait = 0; prev_addr = 0; unstable = 0;
    acc_addr = '{-1, -1};
    done_at = '{-1, -1, -1};
  endtask

  // One clock: at the falling edge observe the DUT and drive the slave response for this cycle.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (done) begin
      if (ndone < 3) done_at[ndone] = cyc;
      ndone++;
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_addr ? cfg_ts : cfg_id;
      end
    end
    if (prev_wait && avm_read && (avm_address != prev_addr)) unstable = 1;
    if (prev_wait && !avm_read && !timeout) unstable = 1;
    prev_wait = 0;
    if (avm_read) begin
      if (ws_cnt < cfg_ws) begin
        ws_cnt++;
        avm_waitrequest = 1'b1;
        prev_wait = 1;
        prev_addr = avm_address;
      end else begin
        ws_cnt = 0;
        if (nreads < 2) acc_addr[nreads] = int'(avm_address);
        nreads++;
        if (cfg_resp) begin
          if (cfg_lat == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = avm_address ? cfg_ts : cfg_id;
          end else begin
            pend      = cfg_lat;
            pend_addr = avm_address;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [31:0] id_val;
    logic [31:0] ts_val;
    int          ws;
    int          lat;
    bit          resp;
    int          exp_done;
    bit          exp_pass;
    bit          exp_id;
    bit          exp_ts;
    bit          exp_tmo;
    int          exp_reads;
  } vec_t;

  vec_t vecs [12];
  int   t0;
  int   rel;

  initial begin
    // id, ts, waitreq cycles, latency, respond, done cycle, pass, id_mm, ts_mm, tmo, reads
    vecs[0]  = '{32'h0000_0000, TS,         0,   0, 1, 5,  1, 0, 0, 0, 2};
    vecs[1]  = '{32'h0000_0001, TS,         0,   0, 1, 5,  0, 1, 0, 0, 2};
    vecs[2]  = '{32'h0000_0000, TS + 32'd1, 0,   0, 1, 5,  0, 0, 1, 0, 2};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0,      0,   0, 1, 5,  0, 1, 1, 0, 2};
    vecs[4]  = '{32'h8000_0000, TS,         0,   0, 1, 5,  0, 1, 0, 0, 2};
    vecs[5]  = '{32'h0000_0000, TS,         3,   0, 1, 11, 1, 0, 0, 0, 2};
    vecs[6]  = '{32'h0000_0000, TS,         0,   2, 1, 9,  1, 0, 0, 0, 2};
    vecs[7]  = '{32'hDEAD_BEEF, TS,         1,   1, 1, 9,  0, 1, 0, 0, 2};
    vecs[8]  = '{32'h0000_0000, TS,         0,   7, 1, 19, 1, 0, 0, 0, 2};
    vecs[9]  = '{32'h0000_0000, TS,         0,   8, 1, 11, 0, 0, 0, 1, 1};
    vecs[10] = '{32'h0000_0000, TS,         0,   0, 0, 11, 0, 0, 0, 1, 1};
    vecs[11] = '{32'h0000_0000, TS,         100, 0, 0, 11, 0, 0, 0, 1, 0};

    cyc = 0;
    reset_slave(32'h0, TS, 0, 0, 1);

    // Reset state.
    #1;
    check("reset_outputs", {24'h0, avm_read, avm_address, busy, done, pass,
                            id_mismatch, ts_mismatch, timeout}, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("idle_no_read", {31'h0, avm_read}, 32'h0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      reset_slave(vecs[i].id_val, vecs[i].ts_val, vecs[i].ws, vecs[i].lat, vecs[i].resp);
      tick(); tick();
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
      for (int k = 0; k < 40 && ndone == 0; k++) begin
        tick();
        if (cyc - t0 == 2)
          check($sformatf("v%0d_cleared_busy", i),
                {27'h0, busy, pass, id_mismatch, ts_mismatch, timeout}, 32'b10000);
      end
      check($sformatf("v%0d_done_cycle", i), 32'(done_at[0] - t0), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_flags", i), {27'h0, busy, pass, id_mismatch, ts_mismatch, timeout},
            {27'h0, 1'b0, vecs[i].exp_pass, vecs[i].exp_id, vecs[i].exp_ts, vecs[i].exp_tmo});
      repeat (4) tick();
      check($sformatf("v%0d_one_done", i), 32'(ndone), 32'd1);
      check($sformatf("v%0d_reads", i), 32'(nreads), 32'(vecs[i].exp_reads));
      check($sformatf("v%0d_stable", i), {31'h0, unstable}, 32'h0);
      if (vecs[i].exp_reads == 2)
        check($sformatf("v%0d_addr_order", i), 32'((acc_addr[0] << 4) | acc_addr[1]), 32'h01);
    end

    // Reset during WAIT_TS, then a late readdatavalid.
    reset_slave(32'h0, TS, 0, 3, 1);
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && (cyc - t0) < 7; k++) tick();
    check("rst_pre_wait_ts", {29'h0, busy, avm_read, avm_address}, 32'b100);
    reset_n = 1'b0;
    #1;
    check("rst_outputs_zero", {24'h0, avm_read, avm_address, busy, done, pass,
                               id_mismatch, ts_mismatch, timeout}, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("rst_no_done", 32'(ndone), 32'd0);
    check("rst_no_new_read", 32'(nreads), 32'd2);
    check("rst_idle_outputs", {24'h0, avm_read, avm_address, busy, done, pass,
                               id_mismatch, ts_mismatch, timeout}, 32'h0);

    // start held through the busy window is ignored.
    reset_slave(32'h0, TS, 0, 0, 1);
    tick();
    start = 1'b1;
    t0 = cyc;
    repeat (5) tick();
    start = 1'b0;
    repeat (10) tick();
    check("busy_start_one_done", 32'(ndone), 32'd1);
    check("busy_start_done_cycle", 32'(done_at[0] - t0), 32'd5);
    check("busy_start_reads", 32'(nreads), 32'd2);

`ifdef SYSID_CHECK_PERIODIC_EN
    // Periodic re-check with no external start.
    reset_slave(32'h0, TS, 0, 0, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rel = cyc;
    for (int k = 0; k < 120 && ndone < 3; k++) tick();
    check("per_first_done", 32'(done_at[0] - rel), 32'd25);
    check("per_interval_1", 32'(done_at[1] - done_at[0]), 32'd25);
    check("per_interval_2", 32'(done_at[2] - done_at[1]), 32'd25);
    check("per_pass", {31'h0, pass}, 32'h1);
`else
    // No periodic build: nothing happens without start.
    reset_slave(32'h0, TS, 0, 0, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rel = cyc;
    repeat (100) tick();
    check("noper_no_done", 32'(ndone), 32'd0);
    check("noper_no_read", 32'(nreads), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
